// File: rtl/usb_packet_arbiter_pkg.sv
// Shared types and constants for the USB packet arbiter.
// Holds the FSM state enum, source IDs and the default burst weight.
package usb_arb_package;

    typedef enum logic [1:0] {
        ARB_IDLE         = 2'd0,
        ARB_GRANT_SAMPLE = 2'd1,
        ARB_GRANT_STATUS = 2'd2
    } usb_arb_state_t;

    localparam logic USB_ARB_SRC_SAMPLE = 1'b0;
    localparam logic USB_ARB_SRC_STATUS = 1'b1;

    localparam int USB_ARB_SAMPLE_BURST = 4;

endpackage

// File: rtl/usb_packet_arbiter_if.sv
// Byte-oriented AXI-Stream bundle shared by the arbiter sources and sink.
// Source drives the beat, Sink returns tready.
interface axis_interface #(
    parameter int DATA_WIDTH = 8
) ();
    localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tid;
    logic                  tdest;
    logic                  tuser;

    modport Source (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport Sink (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/usb_packet_arbiter_counter.sv
// 16-bit wrap-around packet counter used for the optional arbiter stats.
// Reset wins over a coincident increment strobe.
module usb_arb_packet_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] count_o
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    assign count_d = inc_i ? count_q + 16'd1 : count_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/usb_packet_arbiter.sv
// Packet-atomic weighted round-robin arbiter: sample vs status onto USB.
// Define USB_ARB_STATS_EN to build the per-source packet counters.
module usb_packet_arbiter
    import usb_arb_package::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SAMPLE_BURST = USB_ARB_SAMPLE_BURST
) (
    input  logic          clk,
    input  logic          rst,
    axis_interface.Sink   sample_stream,
    axis_interface.Sink   status_stream,
    axis_interface.Source usb_stream
`ifdef USB_ARB_STATS_EN
   ,output logic [15:0]   pkt_count_sample,
    output logic [15:0]   pkt_count_status
`endif
);
    localparam logic [3:0] BURST_MAX = 4'(SAMPLE_BURST);

    usb_arb_state_t state_q, state_d;
    logic [3:0]     burst_q, burst_d;
    logic [3:0]     burst_inc;

    logic [DATA_WIDTH-1:0] data_mux;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  beat_end;
    logic                  s_vld;
    logic                  t_vld;

    assign s_vld = sample_stream.tvalid;
    assign t_vld = status_stream.tvalid;

    // Combinational pass-through from whichever sink currently owns the bus
    always_comb begin
        data_mux         = '0;
        sel_valid        = 1'b0;
        sel_last         = 1'b0;
        usb_stream.tkeep = '0;
        unique case (state_q)
            ARB_GRANT_SAMPLE: begin
                data_mux         = sample_stream.tdata;
                sel_valid        = sample_stream.tvalid;
                sel_last         = sample_stream.tlast;
                usb_stream.tkeep = sample_stream.tkeep;
            end
            ARB_GRANT_STATUS: begin
                data_mux         = status_stream.tdata;
                sel_valid        = status_stream.tvalid;
                sel_last         = status_stream.tlast;
                usb_stream.tkeep = status_stream.tkeep;
            end
            default: ;
        endcase
    end

    assign usb_stream.tdata  = data_mux;
    assign usb_stream.tvalid = sel_valid;
    assign usb_stream.tlast  = sel_last;
    assign usb_stream.tuser  = 1'b0;
    assign usb_stream.tdest  = 1'b0;
    assign usb_stream.tid    = (state_q == ARB_GRANT_STATUS)
                             ? USB_ARB_SRC_STATUS : USB_ARB_SRC_SAMPLE;

    assign sample_stream.tready = (state_q == ARB_GRANT_SAMPLE)
                                & usb_stream.tready;
    assign status_stream.tready = (state_q == ARB_GRANT_STATUS)
                                & usb_stream.tready;

    assign beat_end  = sel_valid & usb_stream.tready & sel_last;
    assign burst_inc = (burst_q < BURST_MAX) ? burst_q + 4'd1 : burst_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (1'b1)
                    (s_vld && !t_vld):
                        state_d = ARB_GRANT_SAMPLE;
                    (!s_vld && t_vld):
                        state_d = ARB_GRANT_STATUS;
                    (s_vld && t_vld && burst_q < BURST_MAX):
                        state_d = ARB_GRANT_SAMPLE;
                    (s_vld && t_vld && burst_q >= BURST_MAX):
                        state_d = ARB_GRANT_STATUS;
                    default: ;
                endcase
            end
            ARB_GRANT_SAMPLE: begin
                if (beat_end) begin
                    state_d = ARB_IDLE;
                    burst_d = t_vld ? burst_inc : 4'd0;
                end
            end
            ARB_GRANT_STATUS: begin
                if (beat_end) begin
                    state_d = ARB_IDLE;
                    burst_d = 4'd0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

`ifdef USB_ARB_STATS_EN
    logic inc_sample;
    logic inc_status;

    assign inc_sample = beat_end & (state_q == ARB_GRANT_SAMPLE);
    assign inc_status = beat_end & (state_q == ARB_GRANT_STATUS);

    usb_arb_packet_counter u_cnt_sample (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_sample),
        .count_o (pkt_count_sample)
    );

    usb_arb_packet_counter u_cnt_status (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_status),
        .count_o (pkt_count_status)
    );
`endif
endmodule

// File: tb/tb_usb_packet_arbiter.sv
// Self-checking bench for usb_packet_arbiter (stats checks need USB_ARB_STATS_EN).
module tb_usb_packet_arbiter;
    import usb_arb_package::*;

    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_interface #(.DATA_WIDTH(8)) sample_if ();
    axis_interface #(.DATA_WIDTH(8)) status_if ();
    axis_interface #(.DATA_WIDTH(8)) usb_if ();

`ifdef USB_ARB_STATS_EN
    logic [15:0] cnt_s;
    logic [15:0] cnt_t;
`endif

    usb_packet_arbiter #(
        .DATA_WIDTH   (8),
        .SAMPLE_BURST (BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_stream (sample_if),
        .status_stream (status_if),
        .usb_stream    (usb_if)
`ifdef USB_ARB_STATS_EN
       ,.pkt_count_sample (cnt_s),
        .pkt_count_status (cnt_t)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic       tid;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } obeat_t;

    typedef struct {
        int n_pre;
        bit sv;
        bit tv;
        bit e_v;
        bit e_tid;
    } vec_t;

    beat_t       sq[$];
    beat_t       tq[$];
    logic [7:0]  sent_s[$];
    logic [7:0]  sent_t[$];
    obeat_t      log_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          s_gate, t_gate, rdy;
    bit          s_hold, t_hold;
    int          m_owner;
    int          m_burst;
    logic [15:0] m_cnt_s, m_cnt_t;

    logic        cur_valid, cur_s_rdy, cur_t_rdy, cur_tid, cur_last;
    logic [7:0]  cur_data;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic add_pkt(bit src, int len, logic [7:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + 8'(i);
            b.last = (i == len - 1);
            if (src) begin
                tq.push_back(b);
                sent_t.push_back(b.data);
            end else begin
                sq.push_back(b);
                sent_s.push_back(b.data);
            end
        end
    endtask

    // One clock: drive sources, check DUT against the packet-level model
    task automatic step();
        bit    sv, tv, e_v, e_sr, e_tr;
        beat_t sb, tb_b, eb;
        logic [31:0] act, exp;
        @(negedge clk);
        sv   = s_hold || (s_gate && sq.size() > 0);
        tv   = t_hold || (t_gate && tq.size() > 0);
        sb   = '0;
        tb_b = '0;
        if (sq.size() > 0) sb = sq[0];
        if (tq.size() > 0) tb_b = tq[0];
        sample_if.tvalid = sv;
        sample_if.tdata  = sb.data;
        sample_if.tlast  = sb.last;
        status_if.tvalid = tv;
        status_if.tdata  = tb_b.data;
        status_if.tlast  = tb_b.last;
        usb_if.tready    = rdy;
        #1;
        cur_valid = usb_if.tvalid;
        cur_s_rdy = sample_if.tready;
        cur_t_rdy = status_if.tready;
        cur_tid   = usb_if.tid;
        cur_data  = usb_if.tdata;
        cur_last  = usb_if.tlast;

        e_v = 0; e_sr = 0; e_tr = 0; eb = '0;
        if (m_owner == 0) begin
            e_v = sv; eb = sb; e_sr = rdy;
        end else if (m_owner == 1) begin
            e_v = tv; eb = tb_b; e_tr = rdy;
        end
        act = {18'b0, cur_s_rdy, cur_t_rdy, cur_valid,
               usb_if.tuser | usb_if.tdest,
               cur_valid ? {cur_tid, cur_data, cur_last} : 10'b0};
        exp = {18'b0, e_sr, e_tr, e_v, 1'b0,
               e_v ? {(m_owner == 1), eb.data, eb.last} : 10'b0};
        chk($sformatf("cycle%0d", cyc), act, exp);

        if (m_owner < 0) begin
            if (sv && !tv)      m_owner = 0;
            else if (!sv && tv) m_owner = 1;
            else if (sv && tv)  m_owner = (m_burst < BURST) ? 0 : 1;
        end else if (e_v && rdy && eb.last) begin
            if (m_owner == 0) begin
                m_burst = tv ? ((m_burst < BURST) ? m_burst + 1 : m_burst) : 0;
                m_cnt_s++;
            end else begin
                m_burst = 0;
                m_cnt_t++;
            end
            m_owner = -1;
        end

        if (sv && cur_s_rdy) begin
            void'(sq.pop_front());
            s_hold = 0;
        end else begin
            s_hold = sv;
        end
        if (tv && cur_t_rdy) begin
            void'(tq.pop_front());
            t_hold = 0;
        end else begin
            t_hold = tv;
        end
        if (cur_valid && rdy)
            log_q.push_back('{cur_tid, cur_data, cur_last, cyc});
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        sample_if.tvalid = 0;
        status_if.tvalid = 0;
        usb_if.tready    = 0;
        @(negedge clk);
        rst = 0;
        sq.delete(); tq.delete(); log_q.delete();
        sent_s.delete(); sent_t.delete();
        s_hold = 0; t_hold = 0;
        m_owner = -1; m_burst = 0;
        m_cnt_s = 0; m_cnt_t = 0;
        s_gate = 1; t_gate = 1; rdy = 1;
    endtask

    task automatic drain();
        int n = 0;
        s_gate = 1; t_gate = 1; rdy = 1;
        while ((sq.size() > 0 || tq.size() > 0 || m_owner >= 0) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 1, 0);
    endtask

    // Per-source byte order on the output must match what each source sent
    task automatic check_streams(string tag);
        logic [7:0] es[$];
        logic [7:0] et[$];
        es = sent_s;
        et = sent_t;
        foreach (log_q[i]) begin
            if (log_q[i].tid) begin
                if (et.size() == 0) chk({tag, "_extra_t"}, 1, 0);
                else chk({tag, "_t"}, log_q[i].data, et.pop_front());
            end else begin
                if (es.size() == 0) chk({tag, "_extra_s"}, 1, 0);
                else chk({tag, "_s"}, log_q[i].data, es.pop_front());
            end
        end
        chk({tag, "_left"}, es.size() + et.size(), 0);
    endtask

    task automatic chk_stats(string tag);
`ifdef USB_ARB_STATS_EN
        chk({tag, "_cnt_s"}, cnt_s, m_cnt_s);
        chk({tag, "_cnt_t"}, cnt_t, m_cnt_t);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        vec_t        vt[8];
        int          ord[10];
        int          sp, tp, k, n, stall;
        logic [7:0]  d_hold;

        sample_if.tvalid = 0; sample_if.tdata = 0; sample_if.tlast = 0;
        sample_if.tkeep = 1; sample_if.tid = 0;
        sample_if.tdest = 0; sample_if.tuser = 0;
        status_if.tvalid = 0; status_if.tdata = 0; status_if.tlast = 0;
        status_if.tkeep = 1; status_if.tid = 1;
        status_if.tdest = 0; status_if.tuser = 0;
        usb_if.tready = 0;

        vt[0] = '{0, 0, 0, 0, 0};
        vt[1] = '{0, 1, 0, 1, 0};
        vt[2] = '{0, 0, 1, 1, 1};
        vt[3] = '{0, 1, 1, 1, 0};
        vt[4] = '{3, 1, 1, 1, 0};
        vt[5] = '{4, 1, 1, 1, 1};
        vt[6] = '{4, 1, 0, 1, 0};
        vt[7] = '{4, 0, 1, 1, 1};

        // Reset state
        do_reset();
        usb_if.tready = 1;
        #1;
        chk("rst_out", {usb_if.tvalid, sample_if.tready, status_if.tready}, 0);
        chk("rst_state", dut.state_q, ARB_IDLE);
        chk("rst_burst", dut.burst_q, 0);
        chk_stats("rst");

        // Idle decision table, burst pre-loaded by sample packets vs pending status
        foreach (vt[v]) begin
            do_reset();
            for (int p = 0; p < vt[v].n_pre; p++) add_pkt(0, 1, 8'hA0 + 8'(p));
            add_pkt(1, 1, 8'hC0);
            for (int c = 0; c < 2 * vt[v].n_pre; c++) step();
            if (vt[v].sv) add_pkt(0, 1, 8'h55);
            s_gate = vt[v].sv;
            t_gate = vt[v].tv;
            if (!vt[v].tv) begin
                t_hold = 0;
                tq.delete();
            end
            step();
            step();
            chk($sformatf("vec%0d", v),
                {cur_valid, cur_valid ? cur_tid : 1'b0},
                {vt[v].e_v, vt[v].e_tid});
        end

        // Sample only: 3 x 4-byte packets with one bubble between packets
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(0, 4, 8'h01);
        drain();
        chk("so_len", log_q.size(), 12);
        for (int j = 0; j < 12 && j < log_q.size(); j++) begin
            chk($sformatf("so_beat%0d", j),
                {log_q[j].tid, log_q[j].data, log_q[j].last},
                {1'b0, 8'(j % 4 + 1), (j % 4 == 3)});
            if (j > 0)
                chk($sformatf("so_gap%0d", j), log_q[j].cyc - log_q[j-1].cyc,
                    (j % 4 == 0) ? 2 : 1);
        end
        chk_stats("so");

        // Contention with 2-byte packets: S,S,S,S,T,S,S,S,S,T
        do_reset();
        for (int p = 0; p < 10; p++) add_pkt(0, 2, 8'(p * 2));
        for (int p = 0; p < 3; p++) add_pkt(1, 2, 8'h80 + 8'(p * 2));
        drain();
        ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        sp = 0; tp = 0; k = 0;
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < 2; b++) begin
                if (k < log_q.size())
                    chk($sformatf("ct_pkt%0d_b%0d", p, b),
                        {log_q[k].tid, log_q[k].data, log_q[k].last},
                        {ord[p][0],
                         ord[p] ? 8'h80 + 8'(tp * 2 + b) : 8'(sp * 2 + b),
                         (b == 1)});
                else
                    chk("ct_short", k, log_q.size());
                k++;
            end
            if (ord[p]) tp++; else sp++;
        end
        check_streams("ct");
        chk_stats("ct");

        // Output backpressure during a status packet
        do_reset();
        add_pkt(1, 3, 8'hB0);
        s_gate = 0;
        step();
        add_pkt(0, 2, 8'h40);
        s_gate = 1;
        rdy = 1; step();
        rdy = 0; step();
        d_hold = cur_data;
        chk("bp_srdy0", cur_s_rdy, 0);
        chk("bp_data0", {cur_data, cur_last}, {8'hB1, 1'b0});
        step();
        chk("bp_srdy1", cur_s_rdy, 0);
        chk("bp_hold", {cur_valid, cur_data, cur_last}, {1'b1, d_hold, 1'b0});
        rdy = 1; step();
        chk("bp_srdy2", cur_s_rdy, 0);
        chk("bp_data2", {cur_data, cur_last}, {8'hB1, 1'b0});
        drain();
        chk("bp_order", {log_q[0].tid, log_q[2].tid, log_q[2].last, log_q[3].tid},
            {1'b1, 1'b1, 1'b1, 1'b0});
        check_streams("bp");

        // Mid-packet sample stall while status waits
        do_reset();
        add_pkt(0, 4, 8'h10);
        add_pkt(1, 2, 8'h90);
        stall = 0; n = 0;
        while ((sq.size() > 0 || tq.size() > 0 || m_owner >= 0) && n < 100) begin
            if (stall < 5 && log_q.size() == 2) begin
                s_gate = 0;
                step();
                stall++;
                chk($sformatf("st_hold%0d", stall),
                    {cur_valid, cur_s_rdy, cur_t_rdy}, 3'b010);
            end else begin
                s_gate = 1;
                step();
            end
            n++;
        end
        chk("st_len", log_q.size(), 6);
        if (log_q.size() == 6)
            chk("st_order", {log_q[3].tid, log_q[3].data, log_q[3].last, log_q[4].tid},
                {1'b0, 8'h13, 1'b1, 1'b1});
        check_streams("st");

        // Reset after the first byte of a packet, with burst weight non-zero
        do_reset();
        add_pkt(0, 1, 8'h01);
        add_pkt(0, 1, 8'h02);
        add_pkt(0, 3, 8'h20);
        add_pkt(1, 1, 8'hE0);
        n = 0;
        while (log_q.size() < 3 && n < 50) begin
            step();
            n++;
        end
        chk("rm_reach", log_q.size(), 3);
        @(negedge clk);
        rst = 1;
        sample_if.tvalid = 0;
        status_if.tvalid = 0;
        @(negedge clk);
        rst = 0;
        usb_if.tready = 1;
        #1;
        chk("rm_out", {usb_if.tvalid, sample_if.tready, status_if.tready}, 0);
        chk("rm_state", dut.state_q, ARB_IDLE);
        chk("rm_burst", dut.burst_q, 0);
`ifdef USB_ARB_STATS_EN
        chk("rm_cnt", {cnt_s, cnt_t}, 0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if (sq.size() < 8 && $urandom_range(0, 2) == 0)
                add_pkt(0, $urandom_range(1, 5), 8'($urandom));
            if (tq.size() < 8 && $urandom_range(0, 7) == 0)
                add_pkt(1, $urandom_range(1, 5), 8'($urandom));
            s_gate = ($urandom_range(0, 9) < 8);
            t_gate = ($urandom_range(0, 9) < 8);
            rdy    = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check_streams("rnd");
        chk_stats("rnd");

`ifdef USB_ARB_STATS_EN
        // Status counter wrap; sample count must not move
        do_reset();
        add_pkt(0, 1, 8'h01);
        drain();
        @(negedge clk);
        force dut.u_cnt_status.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.u_cnt_status.count_q;
        m_cnt_t = 16'hFFFF;
        #1;
        chk("wr_pre", cnt_t, 16'hFFFF);
        add_pkt(1, 2, 8'h70);
        drain();
        step();
        chk("wr_post_t", cnt_t, 16'h0000);
        chk("wr_post_s", cnt_s, 16'h0001);
        chk_stats("wr");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
